// File: rtl/rep_pkg.sv
// rtl/rep_pkg.sv - shared types and width helpers for the repetition-code transmitter
package rep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rep_state_t;

  // Counter width for a modulo-n count; a modulo-1 counter still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_N     = 5;
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_REP_W = cnt_width(DEF_N);
  localparam int unsigned DEF_BIT_W = cnt_width(DEF_W);

endpackage

// File: rtl/rep_counter.sv
// rtl/rep_counter.sv - modulo counter with enable, synchronous clear and terminal count
module rep_counter #(
  parameter int unsigned MOD   = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rep_tx.sv
// rtl/rep_tx.sv - serial repetition-code transmitter, each payload bit sent N times LSB-first
module rep_tx
  import rep_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         tx_bit,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_first,
  output logic         tx_last,
  output logic         busy
);

  localparam int unsigned REP_W = cnt_width(N);
  localparam int unsigned BIT_W = cnt_width(W);

  if (N < 1 || (N % 2) == 0) begin : g_bad_n
    $error("rep_tx: N must be odd and at least 1");
  end
  if (W < 1) begin : g_bad_w
    $error("rep_tx: W must be at least 1");
  end

  rep_state_t       state, state_next;
  logic [W-1:0]     shift_reg;
  logic [REP_W-1:0] rep_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             rep_tc, bit_tc;
  logic             accept, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs decode state only; accept/xfer stay internal so nothing is combinational from inputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    tx_valid   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready) begin
          xfer = 1'b1;
          if (rep_tc && bit_tc) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_bit   = (state == SEND) && shift_reg[0];
  assign tx_first = (state == SEND) && (rep_cnt == '0);
  assign tx_last  = (state == SEND) && rep_tc && bit_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (accept) begin
      shift_reg <= in_data;
    end else if (xfer && rep_tc) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  rep_counter #(.MOD(N), .WIDTH(REP_W)) u_rep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .clr   (accept),
    .count (rep_cnt),
    .tc    (rep_tc)
  );

  rep_counter #(.MOD(W), .WIDTH(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer && rep_tc),
    .clr   (accept),
    .count (bit_cnt),
    .tc    (bit_tc)
  );

  a_rep_range: assert property (@(posedge clk) disable iff (!rst_n) rep_cnt <= REP_W'(N - 1));
  a_bit_range: assert property (@(posedge clk) disable iff (!rst_n) bit_cnt <= BIT_W'(W - 1));

endmodule

// File: tb/tb_rep_tx.sv
// tb/tb_rep_tx.sv - randomized self-checking bench for rep_tx against a symbol-list model
module tb_rep_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, tx_ready = 1'b0;
  logic       in_ready, tx_bit, tx_valid, tx_first, tx_last, busy;

  logic [0:0] b_in_data = '0;
  logic       b_in_valid = 1'b0, b_tx_ready = 1'b0;
  logic       b_in_ready, b_tx_bit, b_tx_valid, b_tx_first, b_tx_last, b_busy;

  rep_tx #(.N(5), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_first(tx_first),
    .tx_last(tx_last), .busy(busy)
  );

  rep_tx #(.N(1), .W(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .tx_bit(b_tx_bit), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_first(b_tx_first),
    .tx_last(b_tx_last), .busy(b_busy)
  );

  int tests = 0;
  int fails = 0;

  bit exp_bit[$], exp_first[$], exp_last[$];
  bit got_bit[$], got_first[$], got_last[$];
  int cap_cycles, cap_stalls, cap_unstable;
  bit cap_timeout, acc_timeout;

  // Expected symbol list: every payload bit, LSB first, repeated n times.
  function automatic void build_model(input int unsigned data, input int n, input int w);
    exp_bit.delete(); exp_first.delete(); exp_last.delete();
    for (int b = 0; b < w; b++) begin
      for (int r = 0; r < n; r++) begin
        exp_bit.push_back(bit'((data >> b) & 1));
        exp_first.push_back(r == 0);
        exp_last.push_back(b == w - 1 && r == n - 1);
      end
    end
  endfunction

  function automatic int seq_errors();
    int e = 0;
    if (got_bit.size() != exp_bit.size()) return 1000;
    for (int i = 0; i < exp_bit.size(); i++)
      if (got_bit[i] != exp_bit[i] || got_first[i] != exp_first[i] || got_last[i] != exp_last[i]) e++;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge of the first transmit cycle.
  task automatic accept_word(input logic [7:0] d);
    acc_timeout = 1'b0;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) acc_timeout = 1'b1;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: ready always, 1: ready toggles 1,0,..., 2: random ready. Returns at the IDLE cycle.
  task automatic capture(input int mode);
    bit done = 1'b0, prev_stall = 1'b0, r;
    logic [2:0] prev = '0;
    got_bit.delete(); got_first.delete(); got_last.delete();
    cap_cycles = 0; cap_stalls = 0; cap_unstable = 0; cap_timeout = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (tx_valid) begin
        if (prev_stall && {tx_bit, tx_first, tx_last} !== prev) cap_unstable++;
        case (mode)
          0:       r = 1'b1;
          1:       r = (cap_cycles % 2 == 0);
          default: r = ($urandom_range(3) != 0);
        endcase
        cap_cycles++;
        tx_ready = r;
        prev = {tx_bit, tx_first, tx_last};
        prev_stall = !r;
        if (r) begin
          got_bit.push_back(tx_bit); got_first.push_back(tx_first); got_last.push_back(tx_last);
          if (tx_last) begin done = 1'b1; break; end
        end else begin
          cap_stalls++;
        end
      end
      @(negedge clk);
    end
    if (done) @(negedge clk);
    else cap_timeout = 1'b1;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; tx_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 1'b1; b_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    tests++; if (tx_bit !== 1'b0) begin fails++; $display("FAIL reset_tx_bit: got %b want 0", tx_bit); end
    tests++; if (tx_first !== 1'b0) begin fails++; $display("FAIL reset_tx_first: got %b want 0", tx_first); end
    tests++; if (tx_last !== 1'b0) begin fails++; $display("FAIL reset_tx_last: got %b want 0", tx_last); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (b_tx_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_min: tx_valid=%b in_ready=%b want 0/1", b_tx_valid, b_in_ready); end
    in_valid = 1'b0; b_in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_no_accept: tx_valid=%b want 0", tx_valid); end
  endtask

  task automatic test_single();
    build_model(8'hA5, 5, 8);
    accept_word(8'hA5);
    capture(0);
    tests++; if (cap_timeout || acc_timeout) begin fails++; $display("FAIL single_timeout: got 1 want 0"); end
    tests++; if (seq_errors() != 0) begin fails++; $display("FAIL single_seq: errors=%0d want 0", seq_errors()); end
    tests++; if (cap_cycles != 40) begin fails++; $display("FAIL single_cycles: got %0d want 40", cap_cycles); end
    tests++; if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
      fails++; $display("FAIL single_idle: in_ready=%b tx_valid=%b want 1/0", in_ready, tx_valid); end
  endtask

  task automatic test_backpressure();
    build_model(8'hA5, 5, 8);
    accept_word(8'hA5);
    capture(1);
    tests++; if (seq_errors() != 0 || cap_timeout) begin fails++; $display("FAIL bp_seq: errors=%0d want 0", seq_errors()); end
    tests++; if (cap_stalls != 39 || cap_cycles != 40 + cap_stalls) begin
      fails++; $display("FAIL bp_cycles: cycles=%0d stalls=%0d want 79/39", cap_cycles, cap_stalls); end
    tests++; if (cap_unstable != 0) begin fails++; $display("FAIL bp_stable: unstable=%0d want 0", cap_unstable); end
  endtask

  task automatic test_busy_overlap();
    build_model(8'hA5, 5, 8);
    accept_word(8'hA5);
    in_data = 8'h3C; in_valid = 1'b1;
    capture(0);
    tests++; if (seq_errors() != 0 || cap_timeout) begin fails++; $display("FAIL overlap_first_word: errors=%0d want 0", seq_errors()); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL overlap_idle: in_ready=%b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL overlap_start: tx_valid=%b want 1", tx_valid); end
    build_model(8'h3C, 5, 8);
    capture(0);
    tests++; if (seq_errors() != 0 || cap_timeout) begin fails++; $display("FAIL overlap_second_word: errors=%0d want 0", seq_errors()); end
  endtask

  task automatic test_reset_mid();
    accept_word(8'hFF);
    tx_ready = 1'b1;
    repeat (17) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (tx_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || tx_bit !== 1'b0) begin
      fails++; $display("FAIL midreset_async: tx_valid=%b busy=%b in_ready=%b tx_bit=%b want 0/0/1/0",
                        tx_valid, busy, in_ready, tx_bit); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build_model(8'h01, 5, 8);
    accept_word(8'h01);
    capture(0);
    tests++; if (seq_errors() != 0 || cap_timeout) begin fails++; $display("FAIL midreset_next_word: errors=%0d want 0", seq_errors()); end
  endtask

  task automatic test_random();
    int bad = 0, bad_t = 0;
    logic [7:0] d;
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      build_model(d, 5, 8);
      accept_word(d);
      capture(2);
      if (seq_errors() != 0 || cap_timeout || acc_timeout) bad++;
      if (cap_unstable != 0 || cap_cycles != 40 + cap_stalls) bad_t++;
      repeat ($urandom_range(2)) @(negedge clk);
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL random_seq: bad words=%0d want 0", bad); end
    tests++; if (bad_t != 0) begin fails++; $display("FAIL random_timing: bad words=%0d want 0", bad_t); end
  endtask

  task automatic test_degenerate();
    int nvalid = 0;
    b_tx_ready = 1'b1;
    b_in_data = 1'b1; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    tests++; if ({b_tx_valid, b_tx_bit, b_tx_first, b_tx_last} !== 4'b1111) begin
      fails++; $display("FAIL min_symbol: valid/bit/first/last=%b%b%b%b want 1111",
                        b_tx_valid, b_tx_bit, b_tx_first, b_tx_last); end
    for (int i = 0; i < 4; i++) begin
      if (b_tx_valid) nvalid++;
      @(negedge clk);
    end
    tests++; if (nvalid != 1) begin fails++; $display("FAIL min_count: valid cycles=%0d want 1", nvalid); end
    tests++; if (b_in_ready !== 1'b1) begin fails++; $display("FAIL min_idle: in_ready=%b want 1", b_in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_busy_overlap();
    test_reset_mid();
    test_random();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
